// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect inputs, program-memory port and IF/ID outputs.
interface fetch_stage_if;

  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_instr_i;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_plus_4_o;
  logic        if_id_valid_o;
  logic        halted_o;
  logic [31:0] fetch_count_o;

  // The fetch stage itself.
  modport master (
    input  stall_i, redirect_valid_i, redirect_pc_i, imem_instr_i,
    output imem_addr_o, pc_o, if_id_instr_o, if_id_pc_plus_4_o,
           if_id_valid_o, halted_o, fetch_count_o
  );

  // The surrounding pipeline: hazard unit, branch resolution, memory, decode.
  modport slave (
    output stall_i, redirect_valid_i, redirect_pc_i, imem_instr_i,
    input  imem_addr_o, pc_o, if_id_instr_o, if_id_pc_plus_4_o,
           if_id_valid_o, halted_o, fetch_count_o
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise hold.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_plus_4_d,
  output logic [31:0] instr_q,
  output logic [31:0] pc_plus_4_q,
  output logic        valid_q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      instr_q     <= NOP_INSTR;
      pc_plus_4_q <= 32'h0;
      valid_q     <= 1'b0;
    end else if (load) begin
      instr_q     <= instr_d;
      pc_plus_4_q <= pc_plus_4_d;
      valid_q     <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BOOT/RUN/HALT control, illegal-address
// detection and the valid-fetch counter; feeds the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 256,
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC
)(
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_plus_4;
  logic [31:0]  fetch_count_q;
  logic         halted_q;
  logic         illegal;
  logic         load;
  logic         bubble;

  assign pc_plus_4 = pc_q + 32'd4;

  // Below-base addresses make the offset wrap, but that case is flagged anyway.
  assign illegal = (pc_q[1:0] != 2'b00) ||
                   (pc_q < RESET_PC) ||
                   (((pc_q - RESET_PC) >> 2) >= 32'(MEMORY_DEPTH));

  always_comb begin
    // NOTE: defaults first so every path assigns; otherwise a latch is inferred.
    load   = 1'b0;
    bubble = 1'b1;
    if (state_q == RUN && !bus.redirect_valid_i && !illegal) begin
      bubble = 1'b0;
      load   = !bus.stall_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_count_q <= 32'h0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (bus.redirect_valid_i) begin
            pc_q <= bus.redirect_pc_i;
          end else if (illegal) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (!bus.stall_i) begin
            pc_q          <= pc_plus_4;
            fetch_count_q <= fetch_count_q + 32'd1;
          end
        end
        HALT: halted_q <= 1'b1;
        default: state_q <= BOOT;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .bubble      (bubble),
    .instr_d     (bus.imem_instr_i),
    .pc_plus_4_d (pc_plus_4),
    .instr_q     (bus.if_id_instr_o),
    .pc_plus_4_q (bus.if_id_pc_plus_4_o),
    .valid_q     (bus.if_id_valid_o)
  );

  assign bus.pc_o          = pc_q;
  assign bus.imem_addr_o   = pc_q;
  assign bus.halted_o      = halted_q;
  assign bus.fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a driver queues the expected post-edge state,
// a monitor pops and compares it after every rising edge.
module tb_fetch_stage;

  typedef struct {
    int          step;
    bit          sel;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   step_no = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  fetch_stage_if bus0();
  fetch_stage_if bus1();

  always #5 clk = ~clk;

  // Program memory: each word encodes its own offset so lost or repeated fetches show.
  function automatic logic [31:0] imem_model(input logic [31:0] addr);
    return 32'h2008_0005 + (addr - 32'h0040_0000);
  endfunction

  assign bus0.imem_instr_i = imem_model(bus0.imem_addr_o);
  assign bus1.imem_instr_i = imem_model(bus1.imem_addr_o);

  fetch_stage u_dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (bus0)
  );

  fetch_stage #(.MEMORY_DEPTH(4)) u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1)
  );

  task automatic check(input string name, input int step,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  // Drive one cycle on the selected DUT and queue the state expected after the edge.
  task automatic cyc(input bit sel, input bit rst, input bit stall, input bit redir,
                     input logic [31:0] tgt, input logic [31:0] e_pc,
                     input logic [31:0] e_instr, input logic [31:0] e_pp4,
                     input bit e_v, input bit e_h, input logic [31:0] e_cnt);
    exp_t e;
    if (!sel) begin
      rst0 = rst;
      bus0.stall_i = stall;
      bus0.redirect_valid_i = redir;
      bus0.redirect_pc_i = tgt;
    end else begin
      rst1 = rst;
      bus1.stall_i = stall;
      bus1.redirect_valid_i = redir;
      bus1.redirect_pc_i = tgt;
    end
    step_no++;
    e.step = step_no;
    e.sel = sel;
    e.pc = e_pc;
    e.instr = e_instr;
    e.pp4 = e_pp4;
    e.valid = e_v;
    e.halted = e_h;
    e.cnt = e_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (!mon_e.sel) begin
        check("pc", mon_e.step, bus0.pc_o, mon_e.pc);
        check("imem_addr", mon_e.step, bus0.imem_addr_o, mon_e.pc);
        check("instr", mon_e.step, bus0.if_id_instr_o, mon_e.instr);
        check("pc_plus_4", mon_e.step, bus0.if_id_pc_plus_4_o, mon_e.pp4);
        check("valid", mon_e.step, 32'(bus0.if_id_valid_o), 32'(mon_e.valid));
        check("halted", mon_e.step, 32'(bus0.halted_o), 32'(mon_e.halted));
        check("count", mon_e.step, bus0.fetch_count_o, mon_e.cnt);
      end else begin
        check("d4_pc", mon_e.step, bus1.pc_o, mon_e.pc);
        check("d4_instr", mon_e.step, bus1.if_id_instr_o, mon_e.instr);
        check("d4_pc_plus_4", mon_e.step, bus1.if_id_pc_plus_4_o, mon_e.pp4);
        check("d4_valid", mon_e.step, 32'(bus1.if_id_valid_o), 32'(mon_e.valid));
        check("d4_halted", mon_e.step, 32'(bus1.halted_o), 32'(mon_e.halted));
        check("d4_count", mon_e.step, bus1.fetch_count_o, mon_e.cnt);
      end
    end
  end

  initial begin
    bus0.stall_i = 1'b0;
    bus0.redirect_valid_i = 1'b0;
    bus0.redirect_pc_i = 32'h0;
    bus1.stall_i = 1'b0;
    bus1.redirect_valid_i = 1'b0;
    bus1.redirect_pc_i = 32'h0;
    @(posedge clk);
    #2;

    // Reset, boot bubble, free run.
    cyc(0, 1, 0, 0, 32'h0,        32'h0040_0000, 32'h0,         32'h0,         0, 0, 0);
    cyc(0, 1, 0, 0, 32'h0,        32'h0040_0000, 32'h0,         32'h0,         0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,        32'h0040_0000, 32'h0,         32'h0,         0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,        32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1, 0, 1);
    cyc(0, 0, 0, 0, 32'h0,        32'h0040_0008, 32'h2008_0009, 32'h0040_0008, 1, 0, 2);
    // Three-cycle stall at 0x00400008, then resume with that word.
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 0, 32'h0,      32'h0040_0008, 32'h2008_0009, 32'h0040_0008, 1, 0, 2);
    cyc(0, 0, 0, 0, 32'h0,        32'h0040_000C, 32'h2008_000D, 32'h0040_000C, 1, 0, 3);
    cyc(0, 0, 0, 0, 32'h0,        32'h0040_0010, 32'h2008_0011, 32'h0040_0010, 1, 0, 4);
    // Redirect wins over a simultaneous stall.
    cyc(0, 0, 1, 1, 32'h0040_0040, 32'h0040_0040, 32'h0,        32'h0,         0, 0, 4);
    cyc(0, 0, 0, 0, 32'h0,        32'h0040_0044, 32'h2008_0045, 32'h0040_0044, 1, 0, 5);
    // Misaligned redirect halts; later redirect and stall are ignored.
    cyc(0, 0, 0, 1, 32'h0040_0042, 32'h0040_0042, 32'h0,        32'h0,         0, 0, 5);
    cyc(0, 0, 0, 0, 32'h0,        32'h0040_0042, 32'h0,         32'h0,         0, 1, 5);
    cyc(0, 0, 0, 1, 32'h0040_0000, 32'h0040_0042, 32'h0,        32'h0,         0, 1, 5);
    cyc(0, 0, 1, 0, 32'h0,        32'h0040_0042, 32'h0,         32'h0,         0, 1, 5);
    // Reset overrides a redirect; BOOT ignores one too.
    cyc(0, 1, 0, 1, 32'h0040_0080, 32'h0040_0000, 32'h0,        32'h0,         0, 0, 0);
    cyc(0, 0, 0, 1, 32'h0040_0080, 32'h0040_0000, 32'h0,        32'h0,         0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,        32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1, 0, 1);
    // Last legal word of a 256-word memory, then one past it.
    cyc(0, 0, 0, 1, 32'h0040_03FC, 32'h0040_03FC, 32'h0,        32'h0,         0, 0, 1);
    cyc(0, 0, 0, 0, 32'h0,        32'h0040_0400, 32'h2008_0401, 32'h0040_0400, 1, 0, 2);
    cyc(0, 0, 0, 0, 32'h0,        32'h0040_0400, 32'h0,         32'h0,         0, 1, 2);
    // Below-base address halts.
    cyc(0, 1, 0, 0, 32'h0,        32'h0040_0000, 32'h0,         32'h0,         0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,        32'h0040_0000, 32'h0,         32'h0,         0, 0, 0);
    cyc(0, 0, 0, 1, 32'h003F_FFFC, 32'h003F_FFFC, 32'h0,        32'h0,         0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,        32'h003F_FFFC, 32'h0,         32'h0,         0, 1, 0);

    // Four-word memory: free run off the end.
    cyc(1, 1, 0, 0, 32'h0,        32'h0040_0000, 32'h0,         32'h0,         0, 0, 0);
    cyc(1, 0, 0, 0, 32'h0,        32'h0040_0000, 32'h0,         32'h0,         0, 0, 0);
    cyc(1, 0, 0, 0, 32'h0,        32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1, 0, 1);
    cyc(1, 0, 0, 0, 32'h0,        32'h0040_0008, 32'h2008_0009, 32'h0040_0008, 1, 0, 2);
    cyc(1, 0, 0, 0, 32'h0,        32'h0040_000C, 32'h2008_000D, 32'h0040_000C, 1, 0, 3);
    cyc(1, 0, 0, 0, 32'h0,        32'h0040_0010, 32'h2008_0011, 32'h0040_0010, 1, 0, 4);
    cyc(1, 0, 0, 0, 32'h0,        32'h0040_0010, 32'h0,         32'h0,         0, 1, 4);
    cyc(1, 0, 0, 0, 32'h0,        32'h0040_0010, 32'h0,         32'h0,         0, 1, 4);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
